fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_write_arbiter_if.sv | 26 ++
 rtl/fifo_write_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side and FIFO-write-side signals of fifo_write_arbiter.
// slave = arbiter view, master = environment (requesters + FIFO) view.
interface fifo_write_arbiter_if #(
    parameter int DATA_LEN = 32,
    parameter int NUM_REQ  = 4
);
    logic [NUM_REQ-1:0]          req_valid_i;
    logic [NUM_REQ*DATA_LEN-1:0] req_data_i;
    logic [NUM_REQ-1:0]          req_last_i;
    logic [NUM_REQ-1:0]          req_ready_o;
    logic                        wfull_i;
    logic                        write_en_o;
    logic [DATA_LEN-1:0]         wdata_o;
    logic [NUM_REQ-1:0]          grant_o;
    logic                        busy_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, wfull_i,
        output req_ready_o, write_en_o, wdata_o, grant_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, wfull_i,
        input  req_ready_o, write_en_o, wdata_o, grant_o, busy_o
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of the FIFO write port; ARB_STATS_EN adds per-requester word counters.
// Latency: 1 cycle request-to-grant, write is combinational in GRANT; 1 bubble cycle between grants.
// Backpressure: wfull_i drops all ready bits and write_en in the same cycle; grant and counters hold.
module fifo_write_arbiter #(
    parameter int DATA_LEN     = 32,
    parameter int NUM_REQ      = 4,
    parameter int BURST_LEN    = 4,
    parameter int IDLE_TIMEOUT = 16,
    localparam int IDX_LEN     = $clog2(NUM_REQ)
) (
    input  logic               wclk,
    input  logic               rst,
    fifo_write_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    input  logic [IDX_LEN-1:0] stat_sel_i,
    output logic [15:0]        stat_count_o
`endif
);
    localparam int BEAT_LEN = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]         state;
    logic [IDX_LEN-1:0] owner;
    logic [IDX_LEN-1:0] rr_ptr;
    logic [BEAT_LEN-1:0] beat_cnt;
    logic [7:0]         idle_cnt;

    logic               sel_found;
    logic [IDX_LEN-1:0] sel_idx;
    logic               busy;
    logic               xfer;
    logic               idle_tick;
    logic               end_burst;
    logic               timeout;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        int k;
        sel_found = 1'b0;
        sel_idx   = '0;
        k         = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(rr_ptr) + i) % NUM_REQ;
            if (bus.req_valid_i[k]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_LEN'(k);
            end
        end
    end

    assign busy      = (state == ST_GRANT);
    assign xfer      = busy && bus.req_valid_i[owner] && !bus.wfull_i;
    assign idle_tick = busy && !bus.req_valid_i[owner] && !bus.wfull_i;
    assign end_burst = bus.req_last_i[owner] || (beat_cnt == BEAT_LEN'(BURST_LEN - 1));
    assign timeout   = idle_tick && (idle_cnt == 8'(IDLE_TIMEOUT - 1));

    always_comb begin
        bus.grant_o     = '0;
        bus.req_ready_o = '0;
        bus.write_en_o  = xfer;
        bus.wdata_o     = '0;
        bus.busy_o      = busy;
        if (busy) begin
            bus.grant_o[owner]     = 1'b1;
            bus.req_ready_o[owner] = !bus.wfull_i;
        end
        if (xfer) begin
            bus.wdata_o = bus.req_data_i[int'(owner) * DATA_LEN +: DATA_LEN];
        end
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        state    <= ST_GRANT;
                        owner    <= sel_idx;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end
                end
                default: begin
                    if ((xfer && end_burst) || timeout) begin
                        state    <= ST_IDLE;
                        rr_ptr   <= (owner == IDX_LEN'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        idle_cnt <= '0;
                    end else if (idle_tick) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stat_cnt [NUM_REQ];

    always_ff @(posedge wclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
        end else if (xfer && (stat_cnt[owner] != 16'hFFFF)) begin
            stat_cnt[owner] <= stat_cnt[owner] + 16'd1;
        end
    end

    assign stat_count_o = (int'(stat_sel_i) < NUM_REQ) ? stat_cnt[stat_sel_i] : 16'd0;
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, round-robin, burst limit, wfull stall, idle timeout, mid-burst reset.
module tb_fifo_write_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;

    logic wclk = 1'b0;
    logic rst  = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fifo_write_arbiter_if #(.DATA_LEN(DW), .NUM_REQ(NR)) bus();

`ifdef ARB_STATS_EN
    logic [1:0]  stat_sel = '0;
    logic [15:0] stat_count;
`endif

    fifo_write_arbiter #(
        .DATA_LEN(DW), .NUM_REQ(NR), .BURST_LEN(4), .IDLE_TIMEOUT(16)
    ) dut (
        .wclk(wclk),
        .rst (rst),
        .bus (bus.slave)
`ifdef ARB_STATS_EN
        ,
        .stat_sel_i  (stat_sel),
        .stat_count_o(stat_count)
`endif
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
        end
    endtask

    // Grant, ready, write enable and data expected for the current cycle.
    task automatic expect_cyc(input string tag, input logic [3:0] g, input logic we, input logic [31:0] wd);
        check({tag, ".grant"}, 64'(bus.grant_o), 64'(g));
        check({tag, ".ready"}, 64'(bus.req_ready_o), bus.wfull_i ? 64'd0 : 64'(g));
        check({tag, ".wen"},   64'(bus.write_en_o), 64'(we));
        check({tag, ".wdata"}, 64'(bus.wdata_o), 64'(wd));
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic l, input logic [31:0] d);
        bus.req_valid_i[k]         = v;
        bus.req_last_i[k]          = l;
        bus.req_data_i[k*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        bus.req_data_i  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        bus.wfull_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_reqs();
        bus.wfull_i = 1'b0;

        // Reset state, with requests asserted during reset
        rst = 1'b1;
        bus.req_valid_i = '1;
        repeat (3) tick();
        #1 expect_cyc("rst", 4'b0000, 1'b0, 32'h0);
        check("rst.busy", 64'(bus.busy_o), 64'd0);

        // Single requester, 3-word packet
        rst = 1'b0;
        clear_reqs();
        set_req(0, 1'b1, 1'b0, 32'hA000_0000);
        #1 expect_cyc("s1.seen", 4'b0000, 1'b0, 32'h0);
        tick();
        #1 expect_cyc("s1.w0", 4'b0001, 1'b1, 32'hA000_0000);
        check("s1.busy", 64'(bus.busy_o), 64'd1);
        tick(); set_req(0, 1'b1, 1'b0, 32'hA000_0001);
        #1 expect_cyc("s1.w1", 4'b0001, 1'b1, 32'hA000_0001);
        tick(); set_req(0, 1'b1, 1'b1, 32'hA000_0002);
        #1 expect_cyc("s1.w2", 4'b0001, 1'b1, 32'hA000_0002);
        tick();
        set_req(0, 1'b1, 1'b1, 32'hA000_0003);
        set_req(1, 1'b1, 1'b1, 32'hA100_0001);
        #1 expect_cyc("s1.bub0", 4'b0000, 1'b0, 32'h0);
        tick();
        #1 expect_cyc("s1.rr1", 4'b0010, 1'b1, 32'hA100_0001);
        tick();
        #1 expect_cyc("s1.bub1", 4'b0000, 1'b0, 32'h0);
        tick();
        #1 expect_cyc("s1.rr0", 4'b0001, 1'b1, 32'hA000_0003);
        tick(); clear_reqs();
        #1 expect_cyc("s1.idle", 4'b0000, 1'b0, 32'h0);

        // Round-robin fairness with 1-word packets from all requesters
        do_reset();
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, 1'b1, 32'hB000_0000 | 32'(k));
        for (int i = 0; i < 40; i++) begin
            #1 expect_cyc("s2.bubble", 4'b0000, 1'b0, 32'h0);
            tick();
            #1 expect_cyc("s2.write", 4'(1 << (i % NR)), 1'b1, 32'hB000_0000 | 32'(i % NR));
            tick();
        end
`ifdef ARB_STATS_EN
        clear_reqs();
        for (int k = 0; k < NR; k++) begin
            stat_sel = 2'(k);
            #1 check("s2.stat", 64'(stat_count), 64'd10);
        end
`endif

        // Burst limit: req 2 never sends last, req 3 waits its turn
        do_reset();
        set_req(2, 1'b1, 1'b0, 32'hC000_0000);
        set_req(3, 1'b1, 1'b1, 32'hD000_0003);
        #1 expect_cyc("s3.bub0", 4'b0000, 1'b0, 32'h0);
        tick();
        for (int b = 0; b < 4; b++) begin
            #1 expect_cyc("s3.burst_a", 4'b0100, 1'b1, 32'hC000_0000 + 32'(b));
            tick(); set_req(2, 1'b1, 1'b0, 32'hC000_0000 + 32'(b + 1));
        end
        #1 expect_cyc("s3.rel", 4'b0000, 1'b0, 32'h0);
        tick();
        #1 expect_cyc("s3.req3", 4'b1000, 1'b1, 32'hD000_0003);
        tick(); set_req(3, 1'b0, 1'b0, 32'h0);
        #1 expect_cyc("s3.bub1", 4'b0000, 1'b0, 32'h0);
        tick();
        for (int b = 4; b < 8; b++) begin
            #1 expect_cyc("s3.burst_b", 4'b0100, 1'b1, 32'hC000_0000 + 32'(b));
            tick(); set_req(2, 1'b1, 1'b0, 32'hC000_0000 + 32'(b + 1));
        end
        #1 expect_cyc("s3.rel2", 4'b0000, 1'b0, 32'h0);

        // wfull stall in the middle of req 1's burst; last coincides with burst limit
        do_reset();
        set_req(1, 1'b1, 1'b0, 32'hE000_0000);
        #1 expect_cyc("s4.bub", 4'b0000, 1'b0, 32'h0);
        tick();
        #1 expect_cyc("s4.w0", 4'b0010, 1'b1, 32'hE000_0000);
        tick(); set_req(1, 1'b1, 1'b0, 32'hE000_0001); bus.wfull_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 expect_cyc("s4.full", 4'b0010, 1'b0, 32'h0);
            check("s4.full.busy", 64'(bus.busy_o), 64'd1);
            tick();
        end
        bus.wfull_i = 1'b0;
        #1 expect_cyc("s4.w1", 4'b0010, 1'b1, 32'hE000_0001);
        tick(); set_req(1, 1'b1, 1'b0, 32'hE000_0002);
        #1 expect_cyc("s4.w2", 4'b0010, 1'b1, 32'hE000_0002);
        tick(); set_req(1, 1'b1, 1'b1, 32'hE000_0003);
        #1 expect_cyc("s4.w3", 4'b0010, 1'b1, 32'hE000_0003);
        tick(); set_req(1, 1'b1, 1'b0, 32'hE000_0004);
        #1 expect_cyc("s4.rel", 4'b0000, 1'b0, 32'h0);
        tick();
        #1 expect_cyc("s4.w4", 4'b0010, 1'b1, 32'hE000_0004);

        // Idle timeout of owner 0, then mid-burst reset
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'hF000_0000);
        set_req(1, 1'b1, 1'b1, 32'hF100_0001);
        #1 expect_cyc("s5.bub", 4'b0000, 1'b0, 32'h0);
        tick();
        #1 expect_cyc("s5.w0", 4'b0001, 1'b1, 32'hF000_0000);
        tick(); set_req(0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            #1 expect_cyc("s5.idle", 4'b0001, 1'b0, 32'h0);
            tick();
        end
        #1 expect_cyc("s5.timeout", 4'b0000, 1'b0, 32'h0);
        tick();
        #1 expect_cyc("s5.req1", 4'b0010, 1'b1, 32'hF100_0001);
        tick(); set_req(1, 1'b0, 1'b0, 32'h0); set_req(2, 1'b1, 1'b0, 32'h1200_0000);
        #1 expect_cyc("s5.bub2", 4'b0000, 1'b0, 32'h0);
        tick();
        #1 expect_cyc("s5.h0", 4'b0100, 1'b1, 32'h1200_0000);
        tick(); set_req(2, 1'b1, 1'b0, 32'h1200_0001); rst = 1'b1;
        #1 expect_cyc("s5.h1", 4'b0100, 1'b1, 32'h1200_0001);
        tick();
        #1 expect_cyc("s5.reset", 4'b0000, 1'b0, 32'h0);
        check("s5.reset.busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;
        set_req(1, 1'b1, 1'b1, 32'h1100_0001);
        tick();
        #1 expect_cyc("s5.rrptr0", 4'b0010, 1'b1, 32'h1100_0001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
